dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter that shares the single-port data memory between the CPU load/store port (master 0) and a debug/program-loader port (master 1). Sits between `cpu`'s datapath and `data_mem`. Requests are accepted with a valid/ready handshake, serialised through a small FSM that drives the memory and waits its fixed read latency, and are then acknowledged with a one-cycle response pulse. Grants alternate round-robin under contention.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- MEM_LAT, 1, cycles from the `mem_en` cycle until `mem_rdata` is valid; legal range 1..7
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- m0_valid / m1_valid  input  1  request present
- m0_we / m1_we  input  1  1 = write, 0 = read
- m0_addr / m1_addr  input  ADDR_W  byte address
- m0_wdata / m1_wdata  input  DATA_W  write data
- m0_wstrb / m1_wstrb  input  DATA_W/8  byte enables for writes
- m0_ready / m1_ready  output  1  request accepted this cycle
- m0_rvalid / m1_rvalid  output  1  one-cycle completion pulse for reads and writes
- m0_rdata / m1_rdata  output  DATA_W  read data, valid while rvalid is high
- mem_en  output  1  one-cycle access strobe
- mem_we  output  1  write enable, qualified by mem_en
- mem_addr  output  ADDR_W  registered address
- mem_wdata  output  DATA_W  registered write data
- mem_wstrb  output  DATA_W/8  registered strobes; 0 for reads
- mem_rdata  input  DATA_W  memory read data

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- On reset, every output is 0, the round-robin pointer favours m0, and the latency counter is 0.
- IDLE:
  - `mX_ready` is asserted combinationally only in IDLE, and only for the granted valid master.
  - With a single requester, that requester is granted.
  - With both requesting, the grant goes to the master not granted last.
  - On handshake (valid & ready), the request fields and the owner ID are registered, the pointer updates, and the FSM moves to WAIT.
- WAIT:
  - Lasts MEM_LAT+1 cycles.
  - `mem_en` is high in the first WAIT cycle only; `mem_we`, `mem_addr`, `mem_wdata`, and `mem_wstrb` hold their values for the whole of WAIT.
  - In the last WAIT cycle, `mem_rdata` is captured into the owner's rdata register.
- RESP: the owner's `rvalid` is high for exactly one cycle, then the FSM returns to IDLE.
- Write responses also pulse rvalid; rdata is left unchanged on writes.
- Each master's rdata holds its value until that master's next read completes.
- A master must hold valid and its fields stable until ready.
- Dropping valid before ready is allowed, is not an error, and does not move the pointer.
- Reset asserted mid-transaction aborts it immediately: no rvalid is issued and no further mem_en is generated.

## Timing
- Handshake in cycle T, mem_en in T+1, mem_rdata sampled at the end of T+1+MEM_LAT, rvalid in T+2+MEM_LAT.
- The next handshake is possible no earlier than T+3+MEM_LAT. With MEM_LAT=1 the period is 4 cycles.
- ready is 0 in WAIT and RESP.
- Outputs mem_* and rvalid/rdata are registered. Only ready is combinational from valid and state.
- Under sustained contention, the grants alternate m0, m1, m0, ...; no master waits longer than one full transaction.

## Configuration
- Macro: `DMEM_ARB_PERF_EN`.
- Defined:
  - Adds outputs `m0_stall_cnt` and `m1_stall_cnt` (32 bits each).
  - Each counts the cycles in which `mX_valid & !mX_ready`.
  - Counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent. Arbitration behaviour is identical in both builds.

## Structure
- Shared package `dmem_arb_pkg`:
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - master ID constants (M_CPU=0, M_DBG=1)
  - legal MEM_LAT bounds
- Sub-module `rr_arb2`: a two-way round-robin grant with inputs req[1:0], pointer, and enable, and output one-hot gnt. The pointer register stays in `dmem_arbiter`.
- The FSM, latency counter, request registers, and optional perf counters live in `dmem_arbiter`.

## Test plan
- Reset, then m0 reads 0x10 with mem_rdata=0xDEADBEEF (MEM_LAT=1): expect m0_ready at T, mem_en at T+1, m0_rvalid and m0_rdata=0xDEADBEEF at T+3, and all outputs 0 during reset.
- m1 writes 0x20 with data 0x12345678, wstrb=4'b0011: expect mem_we=1, mem_wstrb=0011, and mem_addr=0x20 on mem_en; m1_rvalid at T+3; m1_rdata unchanged.
- m0 and m1 both hold valid for 4 transactions: expect the grant order m0, m1, m0, m1, with handshakes every 4 cycles and rvalid only to the owner.
- MEM_LAT=3 read: expect mem_en at T+1, rdata sampled at the end of T+4, rvalid at T+5, and next ready at T+6.
- Assert rst in the WAIT cycle after an m1 read handshake: expect all outputs 0 immediately, no m1_rvalid, and after release an m0 request is granted first.
- With `DMEM_ARB_PERF_EN` defined and both masters contending for 2 transactions: expect m1_stall_cnt=4 and m0_stall_cnt=0 (MEM_LAT=1).

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : dmem_arb_pkg
// Brief   : Shared state encodings, master IDs and latency bounds for dmem_arbiter.
// Revision: 1.0
// ============================================================================
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;
  localparam int LAT_CNT_W   = 3;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way round-robin grant; pointer selects the favoured master on a tie.
// Revision: 1.0
// ============================================================================
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = (ptr == M_DBG) ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Shares one data-memory port between CPU (m0) and debug loader (m1).
//           Optional per-master stall counters when DMEM_ARB_PERF_EN is defined.
// Revision: 1.0
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]         m0_stall_cnt,
  output logic [31:0]         m1_stall_cnt,
`endif
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int c_STRB_W = DATA_W / 8;
  localparam int c_LAT    = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                            (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [LAT_CNT_W-1:0] c_LAT_LAST = LAT_CNT_W'(c_LAT);

  arb_state_t           r_state;
  logic [LAT_CNT_W-1:0] r_lat;
  logic                 r_ptr;
  logic                 r_owner;

  logic [1:0]           w_req;
  logic [1:0]           w_gnt;
  logic                 w_en;
  logic                 w_we;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_wdata;
  logic [c_STRB_W-1:0]  w_wstrb;

  assign w_req = {m1_valid, m0_valid};
  // Gating with rst keeps ready low while reset is held, so every output reads 0.
  assign w_en  = (r_state == IDLE) && !rst;

  rr_arb2 u_rr_arb2 (
    .req (w_req),
    .ptr (r_ptr),
    .en  (w_en),
    .gnt (w_gnt)
  );

  assign m0_ready = w_gnt[0];
  assign m1_ready = w_gnt[1];

  always_comb begin
    w_we    = m0_we;
    w_addr  = m0_addr;
    w_wdata = m0_wdata;
    w_wstrb = m0_wstrb;
    if (w_gnt[1]) begin
      w_we    = m1_we;
      w_addr  = m1_addr;
      w_wdata = m1_wdata;
      w_wstrb = m1_wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lat     <= '0;
      r_ptr     <= M_CPU;
      r_owner   <= M_CPU;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      mem_en    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_owner   <= w_gnt[1];
            r_ptr     <= ~w_gnt[1];
            mem_en    <= 1'b1;
            mem_we    <= w_we;
            mem_addr  <= w_addr;
            mem_wdata <= w_wdata;
            mem_wstrb <= w_we ? w_wstrb : '0;
            r_lat     <= '0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (r_lat == c_LAT_LAST) begin
            if (!mem_we) begin
              if (r_owner == M_DBG) m1_rdata <= mem_rdata;
              else                  m0_rdata <= mem_rdata;
            end
            m0_rvalid <= (r_owner == M_CPU);
            m1_rvalid <= (r_owner == M_DBG);
            r_lat     <= '0;
            r_state   <= RESP;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_stall_cnt <= '0;
      m1_stall_cnt <= '0;
    end else begin
      if (m0_valid && !m0_ready && (m0_stall_cnt != '1)) m0_stall_cnt <= m0_stall_cnt + 32'd1;
      if (m1_valid && !m1_ready && (m1_stall_cnt != '1)) m1_stall_cnt <= m1_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Scoreboard bench for dmem_arbiter at MEM_LAT=1 (index 0) and MEM_LAT=3 (index 1).
// Revision: 1.0
// ============================================================================
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        valid  [2][2];
  logic        we     [2][2];
  logic [31:0] addr   [2][2];
  logic [31:0] wdata  [2][2];
  logic [3:0]  wstrb  [2][2];
  logic        ready  [2][2];
  logic        rvalid [2][2];
  logic [31:0] rdata  [2][2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wstrb [2];
  logic [31:0] mem_rdata [2];
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall [2][2];
`endif

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .m0_valid(valid[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]),
    .m0_wdata(wdata[0][0]), .m0_wstrb(wstrb[0][0]), .m0_ready(ready[0][0]),
    .m0_rvalid(rvalid[0][0]), .m0_rdata(rdata[0][0]),
    .m1_valid(valid[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]),
    .m1_wdata(wdata[0][1]), .m1_wstrb(wstrb[0][1]), .m1_ready(ready[0][1]),
    .m1_rvalid(rvalid[0][1]), .m1_rdata(rdata[0][1]),
`ifdef DMEM_ARB_PERF_EN
    .m0_stall_cnt(stall[0][0]), .m1_stall_cnt(stall[0][1]),
`endif
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .mem_rdata(mem_rdata[0])
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .m0_valid(valid[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]),
    .m0_wdata(wdata[1][0]), .m0_wstrb(wstrb[1][0]), .m0_ready(ready[1][0]),
    .m0_rvalid(rvalid[1][0]), .m0_rdata(rdata[1][0]),
    .m1_valid(valid[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]),
    .m1_wdata(wdata[1][1]), .m1_wstrb(wstrb[1][1]), .m1_ready(ready[1][1]),
    .m1_rvalid(rvalid[1][1]), .m1_rdata(rdata[1][1]),
`ifdef DMEM_ARB_PERF_EN
    .m0_stall_cnt(stall[1][0]), .m1_stall_cnt(stall[1][1]),
`endif
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .mem_rdata(mem_rdata[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ((a ^ 32'hA5A5_0000) + 32'h0000_1111);
  endfunction

  // Memory model: data is presented only in the cycle MEM_LAT cycles after mem_en.
  int          since    [2];
  logic [31:0] lat_addr [2];
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) since[d] <= 0;
      else if (mem_en[d]) begin
        since[d]    <= 1;
        lat_addr[d] <= mem_addr[d];
      end else if (since[d] != 0 && since[d] < 15) since[d] <= since[d] + 1;
    end
  end
  assign mem_rdata[0] = (since[0] == lat_of(0)) ? memval(lat_addr[0]) : 32'hBAD0_BAD0;
  assign mem_rdata[1] = (since[1] == lat_of(1)) ? memval(lat_addr[1]) : 32'hBAD0_BAD0;

  typedef struct { int m; logic [31:0] rdata; int cyc; } rexp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; int cyc; } mexp_t;
  rexp_t       rq0[$], rq1[$];
  mexp_t       mq0[$], mq1[$];
  logic [31:0] last_rd [2][2];
  int          hs_m[$], hs_t[$];
  int          ncmp = 0;
  int          nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d);
    mexp_t me;
    rexp_t re;
    bit    have;
    if (mem_en[d]) begin
      have = 0;
      if (d == 0 && mq0.size() > 0) begin me = mq0.pop_front(); have = 1; end
      if (d == 1 && mq1.size() > 0) begin me = mq1.pop_front(); have = 1; end
      if (!have) begin
        ncmp++; nerr++;
        $display("FAIL d%0d_unexpected_mem_en: got mem_en=1, expected none (cycle %0d)", d, cyc);
      end else begin
        chk($sformatf("d%0d_mem_en_cycle", d), cyc, me.cyc);
        chk($sformatf("d%0d_mem_we", d), mem_we[d], me.we);
        chk($sformatf("d%0d_mem_addr", d), mem_addr[d], me.addr);
        chk($sformatf("d%0d_mem_wdata", d), mem_wdata[d], me.wdata);
        chk($sformatf("d%0d_mem_wstrb", d), mem_wstrb[d], me.wstrb);
      end
    end
    for (int m = 0; m < 2; m++) begin
      if (rvalid[d][m]) begin
        have = 0;
        if (d == 0 && rq0.size() > 0) begin re = rq0.pop_front(); have = 1; end
        if (d == 1 && rq1.size() > 0) begin re = rq1.pop_front(); have = 1; end
        if (!have) begin
          ncmp++; nerr++;
          $display("FAIL d%0d_unexpected_rvalid: got m%0d_rvalid=1, expected none (cycle %0d)", d, m, cyc);
        end else begin
          chk($sformatf("d%0d_rvalid_owner", d), m, re.m);
          chk($sformatf("d%0d_rvalid_cycle", d), cyc, re.cyc);
          chk($sformatf("d%0d_m%0d_rdata", d, m), rdata[d][m], re.rdata);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  task automatic req(input int d, input int m, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] ws, output int t_hs);
    int    n;
    rexp_t re;
    mexp_t me;
    n = 0;
    t_hs = -1;
    we[d][m] = w; addr[d][m] = a; wdata[d][m] = wd; wstrb[d][m] = ws;
    valid[d][m] = 1'b1;
    while (t_hs < 0 && n < 40) begin
      @(negedge clk);
      if (ready[d][m]) t_hs = cyc;
      else n++;
    end
    if (t_hs < 0) begin
      ncmp++; nerr++;
      $display("FAIL d%0d_m%0d_ready_timeout: got no ready in 40 cycles, expected a grant", d, m);
    end else begin
      me.we = w; me.addr = a; me.wdata = wd; me.wstrb = w ? ws : 4'h0; me.cyc = t_hs + 1;
      if (!w) last_rd[d][m] = memval(a);
      re.m = m; re.rdata = last_rd[d][m]; re.cyc = t_hs + 2 + lat_of(d);
      if (d == 0) begin mq0.push_back(me); rq0.push_back(re); end
      else        begin mq1.push_back(me); rq1.push_back(re); end
    end
    @(posedge clk); #1;
    valid[d][m] = 1'b0;
  endtask

  task automatic chk_zero(input string name, input int d);
    chk({name, "_ctl"}, {ready[d][0], ready[d][1], rvalid[d][0], rvalid[d][1],
                         mem_en[d], mem_we[d], mem_wstrb[d]}, 64'd0);
    chk({name, "_rdata"}, {rdata[d][0], rdata[d][1]}, 64'd0);
    chk({name, "_mem"}, {mem_addr[d], mem_wdata[d]}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int  t0, t1, t2, ta, tb, n;
    bit  got;
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) begin
        valid[d][m] = 0; we[d][m] = 0; addr[d][m] = 0; wdata[d][m] = 0; wstrb[d][m] = 0;
        last_rd[d][m] = 0;
      end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_l1", 0);
    chk_zero("reset_l3", 1);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Single read, read, then a partial write from the debug port.
    req(0, 0, 1'b0, 32'h10, 32'h0, 4'h0, t0);
    req(0, 1, 1'b0, 32'h30, 32'h0, 4'h0, t1);
    chk("period_read_read", t1 - t0, 4);
    req(0, 1, 1'b1, 32'h20, 32'h1234_5678, 4'b0011, t2);
    chk("period_read_write", t2 - t1, 4);

    // Sustained contention: grants must alternate starting with m0.
    fork
      begin
        int t;
        for (int k = 0; k < 2; k++) begin
          req(0, 0, 1'b0, 32'h100 + 32'(k * 4), 32'h0, 4'h0, t);
          hs_m.push_back(0); hs_t.push_back(t);
        end
      end
      begin
        int t;
        req(0, 1, 1'b0, 32'h200, 32'h0, 4'h0, t);
        hs_m.push_back(1); hs_t.push_back(t);
        req(0, 1, 1'b1, 32'h204, 32'hCAFE_F00D, 4'hF, t);
        hs_m.push_back(1); hs_t.push_back(t);
      end
    join
    chk("contend_count", hs_m.size(), 4);
    for (int k = 0; k < 4 && k < hs_m.size(); k++)
      chk($sformatf("contend_grant%0d", k), hs_m[k], k % 2);
    for (int k = 1; k < hs_t.size(); k++)
      chk($sformatf("contend_period%0d", k), hs_t[k] - hs_t[k-1], 4);
    repeat (6) @(posedge clk); #1;

    // Reset during WAIT after an m1 read handshake aborts the transaction.
    we[0][1] = 0; addr[0][1] = 32'h300; valid[0][1] = 1;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (ready[0][1]) got = 1; else n++;
    end
    if (!got) begin
      ncmp++; nerr++;
      $display("FAIL abort_ready_timeout: got no ready in 40 cycles, expected a grant");
    end
    @(posedge clk); #1;
    chk("abort_mem_en_before", mem_en[0], 1'b1);
    valid[0][1] = 0;
    rst = 1;
    #1;
    chk_zero("abort_l1", 0);
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) last_rd[d][m] = 0;
    repeat (2) @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("abort_no_m1_rvalid", rvalid[0][1], 1'b0);
    @(posedge clk); #1;

    // After release both request together: m0 must win first.
    hs_m.delete(); hs_t.delete();
    fork
      begin int t; req(0, 0, 1'b0, 32'h400, 32'h0, 4'h0, t); hs_m.push_back(0); hs_t.push_back(t); end
      begin int t; req(0, 1, 1'b0, 32'h404, 32'h0, 4'h0, t); hs_m.push_back(1); hs_t.push_back(t); end
    join
    chk("post_reset_first_m0", (hs_m.size() > 0) ? hs_m[0] : -1, 0);
    chk("post_reset_period", (hs_t.size() > 1) ? hs_t[1] - hs_t[0] : -1, 4);
    repeat (6) @(posedge clk); #1;
`ifdef DMEM_ARB_PERF_EN
    chk("perf_m0_stall", stall[0][0], 32'd0);
    chk("perf_m1_stall", stall[0][1], 32'd4);
`endif

    // MEM_LAT=3: back-to-back reads from m0, next grant six cycles later.
    req(1, 0, 1'b0, 32'h40, 32'h0, 4'h0, ta);
    req(1, 0, 1'b0, 32'h44, 32'h0, 4'h0, tb);
    chk("lat3_period", tb - ta, 6);
    req(1, 1, 1'b1, 32'h48, 32'h5555_AAAA, 4'b1000, ta);
    chk("lat3_write_period", ta - tb, 6);

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rq_drained", rq0.size() + rq1.size(), 0);
    chk("mq_drained", mq0.size() + mq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire
